// File: rtl/fir_serial_deframer.sv
// Rebuilds MSB-first serial FIR results framed by sof_in, rounds/saturates them
// to OUT_W bits and queues them in a show-ahead FIFO behind a valid/ready port.
module fir_serial_deframer #(
    parameter int FRAME_W    = 32,
    parameter int OUT_W      = 16,
    parameter int SHIFT      = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            sof_in,
    input  logic                            sdata_in,
    input  logic                            clr_err,
    output logic [OUT_W-1:0]                m_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow,
    output logic [7:0]                      abort_cnt,
    output logic [7:0]                      sat_cnt
);

    // state    | meaning
    // ST_IDLE  | waiting for sof_in, sdata_in ignored
    // ST_SHIFT | sampling one data bit per cycle, bit_cnt = bits taken so far
    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    localparam int CNT_W = $clog2(FRAME_W);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    // Half-LSB rounding constant; evaluates to 0 when SHIFT is 0.
    localparam logic [FRAME_W:0] RND_U = ({{FRAME_W{1'b0}}, 1'b1} << SHIFT) >> 1;
    localparam logic signed [FRAME_W:0] SAT_MAX = {{(FRAME_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [FRAME_W:0] SAT_MIN = {{(FRAME_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] shreg;
    logic               word_rdy;
    logic               sample, word_done, abort_evt, cnt_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sample    = 1'b0;
        word_done = 1'b0;
        abort_evt = 1'b0;
        cnt_clr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sof_in) begin
                    state_nxt = ST_SHIFT;
                    cnt_clr   = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt == LAST_BIT) begin
                    sample    = 1'b1;
                    word_done = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = sof_in ? ST_SHIFT : ST_IDLE;
                end else if (sof_in) begin
                    abort_evt = 1'b1;
                    cnt_clr   = 1'b1;
                end else begin
                    sample = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            word_rdy <= 1'b0;
        end else begin
            if (sample)
                shreg <= {shreg[FRAME_W-2:0], sdata_in};
            if (cnt_clr)
                bit_cnt <= '0;
            else if (sample)
                bit_cnt <= bit_cnt + CNT_W'(1);
            word_rdy <= word_done;
        end
    end

    // shreg stays intact through the cycle after completion, even when the
    // next frame starts back-to-back, so the scaling reads it directly.
    logic signed [FRAME_W:0] v_ext, rounded, r_shift;
    logic                    sat_hi, sat_lo;
    logic [OUT_W-1:0]        sample_out;

    always_comb begin
        v_ext   = {shreg[FRAME_W-1], shreg};
        rounded = v_ext + $signed(RND_U);
        r_shift = rounded >>> SHIFT;
        sat_hi  = r_shift > SAT_MAX;
        sat_lo  = r_shift < SAT_MIN;
        if (sat_hi)      sample_out = SAT_MAX[OUT_W-1:0];
        else if (sat_lo) sample_out = SAT_MIN[OUT_W-1:0];
        else             sample_out = r_shift[OUT_W-1:0];
    end

    logic push, pop, full, wr_en, ovf_evt, clip_evt;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [OUT_W-1:0] mem [FIFO_DEPTH];

    assign push     = word_rdy;
    assign clip_evt = push & (sat_hi | sat_lo);
    assign full     = (fifo_level == FULL_LVL);
    assign m_valid  = (fifo_level != '0);
    assign pop      = m_valid & m_ready;
    assign wr_en    = push & (~full | pop);
    assign ovf_evt  = push & full & ~pop;
    assign m_data   = m_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= sample_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // clr_err wins over any error event landing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            abort_cnt <= '0;
            sat_cnt   <= '0;
        end else if (clr_err) begin
            overflow  <= 1'b0;
            abort_cnt <= '0;
            sat_cnt   <= '0;
        end else begin
            if (ovf_evt) overflow <= 1'b1;
            if (abort_evt && abort_cnt != 8'hFF) abort_cnt <= abort_cnt + 8'd1;
            if (clip_evt && sat_cnt != 8'hFF)    sat_cnt   <= sat_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_fir_serial_deframer.sv
// Directed bench for fir_serial_deframer at FRAME_W=32, OUT_W=16, SHIFT=15, depth 4.
module tb_fir_serial_deframer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sof_in = 1'b0;
    logic        sdata_in = 1'b0;
    logic        clr_err = 1'b0;
    logic        m_ready = 1'b1;
    logic [15:0] m_data;
    logic        m_valid;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic [7:0]  abort_cnt;
    logic [7:0]  sat_cnt;

    int errors = 0;
    int checks = 0;

    fir_serial_deframer #(.FRAME_W(32), .OUT_W(16), .SHIFT(15), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .sof_in(sof_in), .sdata_in(sdata_in), .clr_err(clr_err),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .fifo_level(fifo_level),
        .overflow(overflow), .abort_cnt(abort_cnt), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        sof_in = 1'b1;
        sdata_in = 1'b0;
        tick();
        sof_in = 1'b0;
    endtask

    // Shifts 32 bits MSB first; sof_last raises sof_in together with the final bit.
    task automatic shift_frame(input logic [31:0] w, input bit sof_last);
        for (int i = 31; i >= 0; i--) begin
            sdata_in = w[i];
            sof_in = sof_last && (i == 0);
            tick();
        end
        sof_in = 1'b0;
        sdata_in = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] w);
        start_frame();
        shift_frame(w, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", m_valid); end
        checks++; if (m_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", m_data); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
        checks++; if ({overflow, abort_cnt, sat_cnt} !== 17'd0) begin errors++; $display("FAIL reset_errs: got ovf=%b abort=%0d sat=%0d expected all 0", overflow, abort_cnt, sat_cnt); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        send_frame(32'h0001_8000);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0 one cycle after last bit", m_valid); end
        tick();
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1 two cycles after last bit", m_valid); end
        checks++; if (m_data !== 16'h0003) begin errors++; $display("FAIL basic_data: got %h expected 0003", m_data); end
        checks++; if (sat_cnt !== 8'd0) begin errors++; $display("FAIL basic_sat: got %0d expected 0", sat_cnt); end
        tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_pop: got valid %b expected 0", m_valid); end
    endtask

    task automatic test_rounding();
        send_frame(32'hFFFF_C000);
        tick();
        checks++; if (m_valid !== 1'b1 || m_data !== 16'h0000) begin errors++; $display("FAIL round_neg_half: got v=%b d=%h expected v=1 d=0000", m_valid, m_data); end
        send_frame(32'h0000_8000);
        tick();
        checks++; if (m_valid !== 1'b1 || m_data !== 16'h0001) begin errors++; $display("FAIL round_pos: got v=%b d=%h expected v=1 d=0001", m_valid, m_data); end
        tick();
    endtask

    task automatic test_saturation();
        send_frame(32'h7FFF_FFFF);
        tick();
        checks++; if (m_data !== 16'h7FFF) begin errors++; $display("FAIL sat_pos: got %h expected 7fff", m_data); end
        send_frame(32'h8000_0000);
        tick();
        checks++; if (m_data !== 16'h8000) begin errors++; $display("FAIL sat_neg: got %h expected 8000", m_data); end
        checks++; if (sat_cnt !== 8'd2) begin errors++; $display("FAIL sat_cnt: got %0d expected 2", sat_cnt); end
        tick();
    endtask

    task automatic test_abort();
        start_frame();
        for (int i = 0; i < 10; i++) begin
            sdata_in = 1'b1;
            tick();
        end
        send_frame(32'h0000_8000);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL abort_spurious: got valid %b expected 0", m_valid); end
        checks++; if (abort_cnt !== 8'd1) begin errors++; $display("FAIL abort_cnt: got %0d expected 1", abort_cnt); end
        tick();
        checks++; if (m_valid !== 1'b1 || m_data !== 16'h0001) begin errors++; $display("FAIL abort_next_word: got v=%b d=%h expected v=1 d=0001", m_valid, m_data); end
        tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL abort_single: got valid %b expected 0", m_valid); end
    endtask

    task automatic test_back_to_back();
        m_ready = 1'b0;
        start_frame();
        shift_frame(32'h0001_0000, 1'b1);
        shift_frame(32'h0001_8000, 1'b0);
        tick();
        checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL b2b_level: got %0d expected 2", fifo_level); end
        checks++; if (m_data !== 16'h0002) begin errors++; $display("FAIL b2b_first: got %h expected 0002", m_data); end
        checks++; if (abort_cnt !== 8'd1) begin errors++; $display("FAIL b2b_no_abort: got %0d expected 1", abort_cnt); end
        m_ready = 1'b1;
        tick();
        checks++; if (m_data !== 16'h0003) begin errors++; $display("FAIL b2b_second: got %h expected 0003", m_data); end
        tick();
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL b2b_drain: got %0d expected 0", fifo_level); end
    endtask

    task automatic test_overflow();
        logic [15:0] exp_d;
        m_ready = 1'b0;
        for (int k = 1; k <= 5; k++) send_frame(32'(k) << 15);
        tick();
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d expected 4", fifo_level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        checks++; if (m_data !== 16'h0001) begin errors++; $display("FAIL ovf_hold: got %h expected 0001", m_data); end
        m_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            exp_d = 16'(k);
            checks++; if (m_valid !== 1'b1 || m_data !== exp_d) begin errors++; $display("FAIL ovf_drain_%0d: got v=%b d=%h expected v=1 d=%h", k, m_valid, m_data, exp_d); end
            tick();
        end
        checks++; if (fifo_level !== 3'd0 || m_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got level=%0d v=%b expected 0 0", fifo_level, m_valid); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
        checks++; if (abort_cnt !== 8'd0 || sat_cnt !== 8'd0) begin errors++; $display("FAIL clr_counts: got abort=%0d sat=%0d expected 0 0", abort_cnt, sat_cnt); end
    endtask

    task automatic test_reset_midframe();
        m_ready = 1'b0;
        for (int k = 1; k <= 4; k++) send_frame(32'(k) << 15);
        tick();
        start_frame();
        for (int i = 0; i < 10; i++) begin
            sdata_in = 1'b1;
            tick();
        end
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL rstmid_pre_level: got %0d expected 4", fifo_level); end
        rst = 1'b1;
        #1;
        checks++; if (m_valid !== 1'b0 || m_data !== 16'h0000 || fifo_level !== 3'd0) begin errors++; $display("FAIL rstmid_fifo: got v=%b d=%h level=%0d expected 0 0 0", m_valid, m_data, fifo_level); end
        checks++; if ({overflow, abort_cnt, sat_cnt} !== 17'd0) begin errors++; $display("FAIL rstmid_errs: got ovf=%b abort=%0d sat=%0d expected all 0", overflow, abort_cnt, sat_cnt); end
        tick();
        rst = 1'b0;
        m_ready = 1'b1;
        tick();
        send_frame(32'h0001_8000);
        tick();
        checks++; if (m_valid !== 1'b1 || m_data !== 16'h0003) begin errors++; $display("FAIL rstmid_next: got v=%b d=%h expected v=1 d=0003", m_valid, m_data); end
        checks++; if (abort_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_abort: got %0d expected 0", abort_cnt); end
        tick();
    endtask

    task automatic test_counter_limits();
        // Holding sof_in high aborts every cycle once in SHIFT.
        sof_in = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        checks++; if (abort_cnt !== 8'd255) begin errors++; $display("FAIL abort_hold: got %0d expected 255", abort_cnt); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++; if (abort_cnt !== 8'd0) begin errors++; $display("FAIL clr_priority: got %0d expected 0", abort_cnt); end
        tick();
        checks++; if (abort_cnt !== 8'd1) begin errors++; $display("FAIL abort_after_clr: got %0d expected 1", abort_cnt); end
        sof_in = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_abort();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        test_counter_limits();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
